i2c_master_ctrl: RTL

Single-byte I2C master controller. It sequences one complete bus transaction per request: START, a 7-bit address plus R/W bit, the address ACK, one data byte, the data ACK/NACK, then STOP. SCL is generated internally by a quarter-period phase counter, which replaces the standalone divide-by-4 SCL generator. It sits between a register/CPU-side requester and the open-drain SCL/SDA pads.

---
 rtl/i2c_master_ctrl_if.sv | 41 ++++
 rtl/i2c_master_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: request/response and pad bundle for the single-byte I2C master.
//   Requester side : start, addr[6:0], rw, wdata[7:0] in; busy, done, ack_err, rdata[7:0] out
//   Pad side       : scl, sda_oe out; sda_in (and scl_in when I2C_CLK_STRETCH_EN) in
// modport master is the controller itself; modport slave is whatever drives/observes it.
// Optional feature macro: I2C_CLK_STRETCH_EN adds the scl_in pad-sense signal.
interface i2c_master_ctrl_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       sda_in;
`ifdef I2C_CLK_STRETCH_EN
    logic       scl_in;
`endif
    logic       scl;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

`ifdef I2C_CLK_STRETCH_EN
    modport master (
        input  start, addr, rw, wdata, sda_in, scl_in,
        output scl, sda_oe, busy, done, ack_err, rdata
    );
    modport slave (
        output start, addr, rw, wdata, sda_in, scl_in,
        input  scl, sda_oe, busy, done, ack_err, rdata
    );
`else
    modport master (
        input  start, addr, rw, wdata, sda_in,
        output scl, sda_oe, busy, done, ack_err, rdata
    );
    modport slave (
        output start, addr, rw, wdata, sda_in,
        input  scl, sda_oe, busy, done, ack_err, rdata
    );
`endif
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master. One request runs START, {addr,rw}, address ACK,
// one data byte, data ACK/NACK, STOP. SCL comes from an internal quarter-period counter.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : i2c_master_ctrl_if.master (start/addr/rw/wdata/sda_in in;
//          scl/sda_oe/busy/done/ack_err/rdata out)
// Parameter QUARTER: clk cycles per SCL quarter-period (>= 1); one bit slot = 4*QUARTER clks.
// Optional feature macro: I2C_CLK_STRETCH_EN -- honour slave clock stretching via bus.scl_in.
module i2c_master_ctrl #(
    parameter int unsigned QUARTER = 1
) (
    input logic               clk,
    input logic               rst,
    i2c_master_ctrl_if.master bus
);
    localparam int unsigned      TickW    = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(QUARTER - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StAddr  = 3'd2;
    localparam logic [2:0] StAck1  = 3'd3;
    localparam logic [2:0] StData  = 3'd4;
    localparam logic [2:0] StAck2  = 3'd5;
    localparam logic [2:0] StStop  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [TickW-1:0] tick_q;
    logic [1:0]       qtr_q;
    logic [2:0]       bit_q;
    logic [7:0]       addr_rw_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rx_q;
    logic [7:0]       rdata_q;
    logic             ack_err_q;
    logic             done_q;

    logic stall, qtr_end, slot_end, sample, capture;
    logic scl_o, sda_oe_o;

    assign capture = (state_q == StIdle) && bus.start;

`ifdef I2C_CLK_STRETCH_EN
    // Hold on the first clk of q2 while a slave keeps SCL low; sampling stays tied to the rise.
    assign stall = (state_q != StIdle) && (qtr_q == 2'd2) && (tick_q == '0) && !bus.scl_in;
`else
    assign stall = 1'b0;
`endif

    assign qtr_end  = (state_q != StIdle) && (tick_q == TickLast) && !stall;
    assign slot_end = qtr_end && (qtr_q == 2'd3);
    assign sample   = qtr_end && (qtr_q == 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StStart;
            StStart: if (slot_end) state_d = StAddr;
            StAddr:  if (slot_end && bit_q == 3'd7) state_d = StAck1;
            // ack_err_q was set by the ACK1 sample one quarter earlier
            StAck1:  if (slot_end) state_d = ack_err_q ? StStop : StData;
            StData:  if (slot_end && bit_q == 3'd7) state_d = StAck2;
            StAck2:  if (slot_end) state_d = StStop;
            StStop:  if (slot_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == StIdle) begin
                tick_q <= '0;
                qtr_q  <= 2'd0;
                bit_q  <= 3'd0;
            end else if (qtr_end) begin
                tick_q <= '0;
                qtr_q  <= qtr_q + 2'd1;
                if (qtr_q == 2'd3) bit_q <= bit_q + 3'd1;
            end else if (!stall) begin
                tick_q <= tick_q + TickW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_rw_q <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            rdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StStop) && slot_end;
            if (capture) begin
                addr_rw_q <= {bus.addr, bus.rw};
                wdata_q   <= bus.wdata;
                ack_err_q <= 1'b0;
            end
            if (sample) begin
                case (state_q)
                    StAck1:  if (bus.sda_in) ack_err_q <= 1'b1;
                    StAck2:  if (!addr_rw_q[0] && bus.sda_in) ack_err_q <= 1'b1;
                    StData:  if (addr_rw_q[0]) rx_q <= {rx_q[6:0], bus.sda_in};
                    default: ;
                endcase
            end
            // On a read, ack_err can only come from ACK1, so clear means a real data byte
            if ((state_q == StStop) && slot_end && addr_rw_q[0] && !ack_err_q) begin
                rdata_q <= rx_q;
            end
        end
    end

    always_comb begin
        scl_o    = 1'b1;
        sda_oe_o = 1'b0;
        case (state_q)
            StStart: begin
                scl_o    = (qtr_q != 2'd3);
                sda_oe_o = qtr_q[1];
            end
            StAddr: begin
                scl_o    = qtr_q[1];
                sda_oe_o = ~addr_rw_q[3'd7 - bit_q];
            end
            StAck1, StAck2: begin
                scl_o    = qtr_q[1];
                sda_oe_o = 1'b0;
            end
            StData: begin
                scl_o    = qtr_q[1];
                sda_oe_o = ~addr_rw_q[0] & ~wdata_q[3'd7 - bit_q];
            end
            StStop: begin
                scl_o    = (qtr_q != 2'd0);
                sda_oe_o = ~qtr_q[1];
            end
            default: begin
                scl_o    = 1'b1;
                sda_oe_o = 1'b0;
            end
        endcase
    end

    assign bus.scl     = scl_o;
    assign bus.sda_oe  = sda_oe_o;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.rdata   = rdata_q;
endmodule
